// File: rtl/uart_loader_if.sv
// Write/handshake bundle between the UART frame loader and the display back buffer.
// The loader side takes the master modport; the memory/top side takes the slave modport.
interface uart_loader_if #(
    parameter int segments = 2,
    parameter int rows     = 8,
    parameter int columns  = 32,
    parameter int bitwidth = 8
);
    localparam int W  = bitwidth * 3 * segments;
    localparam int RW = (rows > 1) ? $clog2(rows) : 1;
    localparam int CW = (columns > 1) ? $clog2(columns) : 1;

    logic          rxi;
    logic          ready;
    logic [W-1:0]  wdata;
    logic          wen;
    logic [RW-1:0] wrow;
    logic [CW-1:0] wcol;
    logic          loaded;
    logic          frame_error;

    modport master (
        input  rxi, ready,
        output wdata, wen, wrow, wcol, loaded, frame_error
    );

    modport slave (
        output rxi, ready,
        input  wdata, wen, wrow, wcol, loaded, frame_error
    );
endinterface

// File: rtl/uart_loader.sv
// 8N1 UART receiver feeding a frame assembler: a 0xA5 sync byte opens a frame, then
// B bytes per pixel word are packed MSB-first and written row-major into the back buffer.
module uart_loader #(
    parameter int segments     = 2,
    parameter int rows         = 8,
    parameter int columns      = 32,
    parameter int bitwidth     = 8,
    parameter int clks_per_bit = 104
) (
    input  logic            clk,
    input  logic            rst,
    uart_loader_if.master   lb
);
    localparam int W      = bitwidth * 3 * segments;
    localparam int B      = W / 8;
    localparam int RW     = (rows > 1) ? $clog2(rows) : 1;
    localparam int CW     = (columns > 1) ? $clog2(columns) : 1;
    localparam int BIDX_W = (B > 1) ? $clog2(B) : 1;
    localparam int CNT_W  = $clog2(clks_per_bit);
    localparam int HALF   = clks_per_bit / 2;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {F_IDLE, F_DATA} f_state_t;

    rx_state_t          r_rx_state, w_rx_next;
    f_state_t           r_f_state, w_f_next;

    logic               r_sync1, r_sync2;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_rxsh;
    logic               w_half, w_tick;
    logic               w_byte_valid, w_ferr;

    logic [W-9:0]       r_shreg;
    logic [BIDX_W-1:0]  r_bidx;
    logic [RW-1:0]      r_row;
    logic [CW-1:0]      r_col;
    logic [W-1:0]       r_wdata;
    logic [RW-1:0]      r_wrow;
    logic [CW-1:0]      r_wcol;
    logic               r_wen, r_pend, r_loaded;
    logic [W-1:0]       w_word;
    logic               w_last_row, w_last_col;
    logic               w_start, w_word_done, w_frame_end;

    assign w_half     = (r_cnt == CNT_W'(HALF));
    assign w_tick     = (r_cnt == CNT_W'(clks_per_bit - 1));
    assign w_word     = {r_shreg, r_rxsh};
    assign w_last_row = (r_row == RW'(rows - 1));
    assign w_last_col = (r_col == CW'(columns - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= lb.rxi;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= RX_IDLE;
        else     r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (!r_sync2) w_rx_next = RX_START;
            RX_START: if (w_half) w_rx_next = r_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_tick && (r_bit == 3'd7)) w_rx_next = RX_STOP;
            RX_STOP:  if (w_tick) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    // Stop bit is judged at its midpoint, then RX is idle again for back-to-back bytes.
    always_comb begin
        w_byte_valid = (r_rx_state == RX_STOP) && w_tick && r_sync2;
        w_ferr       = (r_rx_state == RX_STOP) && w_tick && !r_sync2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_bit  <= '0;
            r_rxsh <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                end
                RX_START: r_cnt <= w_half ? '0 : r_cnt + CNT_W'(1);
                RX_DATA: begin
                    if (w_tick) begin
                        r_cnt  <= '0;
                        r_bit  <= r_bit + 3'd1;
                        r_rxsh <= {r_sync2, r_rxsh[7:1]};
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: r_cnt <= w_tick ? '0 : r_cnt + CNT_W'(1);
                default: r_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_f_state <= F_IDLE;
        else     r_f_state <= w_f_next;
    end

    always_comb begin
        w_f_next = r_f_state;
        case (r_f_state)
            F_IDLE: if (w_start) w_f_next = F_DATA;
            F_DATA: if (w_ferr || w_frame_end) w_f_next = F_IDLE;
            default: w_f_next = F_IDLE;
        endcase
    end

    always_comb begin
        w_start     = (r_f_state == F_IDLE) && w_byte_valid && (r_rxsh == 8'hA5) && lb.ready;
        w_word_done = (r_f_state == F_DATA) && w_byte_valid && (r_bidx == BIDX_W'(B - 1));
        w_frame_end = w_word_done && w_last_row && w_last_col;
    end

    // loaded trails the final wen by one cycle via r_pend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg  <= '0;
            r_bidx   <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_wdata  <= '0;
            r_wrow   <= '0;
            r_wcol   <= '0;
            r_wen    <= 1'b0;
            r_pend   <= 1'b0;
            r_loaded <= 1'b0;
        end else begin
            r_wen    <= w_word_done;
            r_pend   <= w_frame_end;
            r_loaded <= r_pend;
            if (w_start) begin
                r_bidx <= '0;
                r_row  <= '0;
                r_col  <= '0;
            end else if ((r_f_state == F_DATA) && w_byte_valid) begin
                r_shreg <= w_word[W-9:0];
                if (w_word_done) begin
                    r_bidx  <= '0;
                    r_wdata <= w_word;
                    r_wrow  <= r_row;
                    r_wcol  <= r_col;
                    if (w_last_col) begin
                        r_col <= '0;
                        r_row <= w_last_row ? '0 : r_row + RW'(1);
                    end else begin
                        r_col <= r_col + CW'(1);
                    end
                end else begin
                    r_bidx <= r_bidx + BIDX_W'(1);
                end
            end
        end
    end

    assign lb.wdata       = r_wdata;
    assign lb.wen         = r_wen;
    assign lb.wrow        = r_wrow;
    assign lb.wcol        = r_wcol;
    assign lb.loaded      = r_loaded;
    assign lb.frame_error = w_ferr;
endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader on a reduced 4x8 panel geometry at 8 clocks per bit.
// Expected writes come from a frame-level model: word k of a frame is bytes 6k..6k+5 at (k/cols, k%cols).
module tb_uart_loader;
    localparam int SEG  = 2;
    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int BW   = 8;
    localparam int CPB  = 8;
    localparam int W    = BW * 3 * SEG;
    localparam int B    = W / 8;
    localparam int NW   = ROWS * COLS;
    localparam int FB   = NW * B;
    localparam int RW   = $clog2(ROWS);
    localparam int CW   = $clog2(COLS);

    typedef struct {
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic [W-1:0]  data;
        bit            last;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_loader_if #(.segments(SEG), .rows(ROWS), .columns(COLS), .bitwidth(BW)) lb ();

    uart_loader #(
        .segments(SEG), .rows(ROWS), .columns(COLS), .bitwidth(BW), .clks_per_bit(CPB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .lb  (lb)
    );

    int vectors = 0;
    int miscompares = 0;
    int wen_cnt = 0, loaded_cnt = 0, ferr_cnt = 0, byte_cnt = 0;
    logic [7:0] last_byte = 8'h00;
    bit loaded_due = 1'b0;
    wr_t exp_q[$];
    logic [7:0] frame[FB];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic build_frame(input int kind);
        for (int i = 0; i < FB; i++) begin
            case (kind)
                0:       frame[i] = 8'(i);
                1:       frame[i] = 8'(255 - i);
                default: frame[i] = 8'(i * 7 + 3);
            endcase
        end
    endtask

    task automatic expect_words(input int nwords, input bit full);
        wr_t e;
        for (int k = 0; k < nwords; k++) begin
            e.row  = RW'(k / COLS);
            e.col  = CW'(k % COLS);
            e.data = '0;
            for (int j = 0; j < B; j++) e.data = {e.data[W-9:0], frame[k*B + j]};
            e.last = full && (k == NW - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopb);
        lb.rxi = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            lb.rxi = b[i];
            repeat (CPB) @(negedge clk);
        end
        lb.rxi = stopb;
        repeat (CPB) @(negedge clk);
        lb.rxi = 1'b1;
    endtask

    task automatic send_frame(input int nbytes);
        send_byte(8'hA5, 1'b1);
        for (int i = 0; i < nbytes; i++) send_byte(frame[i], 1'b1);
    endtask

    task automatic idle_bits(input int n);
        repeat (n * CPB) @(negedge clk);
    endtask

    // Every cycle out of reset: writes against the model queue, loaded exactly one cycle after the last word.
    always @(negedge clk) begin
        wr_t e;
        if (rst) begin
            loaded_due = 1'b0;
        end else begin
            if (dut.w_byte_valid) begin
                byte_cnt++;
                last_byte = dut.r_rxsh;
            end
            if (lb.frame_error) begin
                ferr_cnt++;
                check("ferr_with_byte_valid", 64'(dut.w_byte_valid), 64'd0);
            end
            check("loaded", 64'(lb.loaded), 64'(loaded_due));
            if (lb.loaded) loaded_cnt++;
            loaded_due = 1'b0;
            if (lb.wen) begin
                wen_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_wen", 64'(lb.wen), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wrow", 64'(lb.wrow), 64'(e.row));
                    check("wcol", 64'(lb.wcol), 64'(e.col));
                    check("wdata", 64'(lb.wdata), 64'(e.data));
                    loaded_due = e.last;
                end
            end
        end
    end

    initial begin
        int b0, w0, l0, f0;
        lb.rxi   = 1'b1;
        lb.ready = 1'b1;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wen", 64'(lb.wen), 64'd0);
        check("rst_loaded", 64'(lb.loaded), 64'd0);
        check("rst_ferr", 64'(lb.frame_error), 64'd0);
        check("rst_wdata", 64'(lb.wdata), 64'd0);
        check("rst_wrow", 64'(lb.wrow), 64'd0);
        check("rst_wcol", 64'(lb.wcol), 64'd0);
        check("rst_sync", 64'(dut.r_sync2), 64'd1);
        rst = 1'b0;
        idle_bits(1);

        // single byte 0x3C after a sync byte
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        idle_bits(2);
        check("byte_3c", 64'(last_byte), 64'h3C);
        check("byte_count", 64'(byte_cnt), 64'd2);
        check("byte_no_ferr", 64'(ferr_cnt), 64'd0);
        check("byte_in_fdata", 64'(dut.r_f_state), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_bits(1);

        // short glitch on the line
        b0 = byte_cnt;
        lb.rxi = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        lb.rxi = 1'b1;
        idle_bits(3);
        check("glitch_no_byte", 64'(byte_cnt), 64'(b0));
        check("glitch_no_ferr", 64'(ferr_cnt), 64'd0);
        check("glitch_rx_idle", 64'(dut.r_rx_state), 64'd0);

        // sync while not ready
        lb.ready = 1'b0;
        send_byte(8'hA5, 1'b1);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
        idle_bits(2);
        check("notready_wen", 64'(wen_cnt), 64'd0);
        check("notready_loaded", 64'(loaded_cnt), 64'd0);
        check("notready_fidle", 64'(dut.r_f_state), 64'd0);
        lb.ready = 1'b1;

        // full frame of incrementing bytes
        build_frame(0);
        expect_words(NW, 1'b1);
        check("model_first_data", 64'(exp_q[0].data), 64'h000102030405);
        check("model_last_data", 64'(exp_q[NW-1].data), 64'hBABBBCBDBEBF);
        check("model_last_row", 64'(exp_q[NW-1].row), 64'd3);
        check("model_last_col", 64'(exp_q[NW-1].col), 64'd7);
        w0 = wen_cnt; l0 = loaded_cnt;
        send_frame(FB);
        idle_bits(2);
        check("frame1_wen", 64'(wen_cnt - w0), 64'(NW));
        check("frame1_loaded", 64'(loaded_cnt - l0), 64'd1);
        check("frame1_drained", 64'(exp_q.size()), 64'd0);
        check("frame1_fidle", 64'(dut.r_f_state), 64'd0);

        // bad stop bit on the third data byte aborts the frame
        w0 = wen_cnt; f0 = ferr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b0);
        idle_bits(3);
        check("abort_ferr", 64'(ferr_cnt - f0), 64'd1);
        check("abort_no_wen", 64'(wen_cnt - w0), 64'd0);
        check("abort_fidle", 64'(dut.r_f_state), 64'd0);
        build_frame(1);
        expect_words(NW, 1'b1);
        w0 = wen_cnt; l0 = loaded_cnt;
        send_frame(FB);
        idle_bits(2);
        check("frame2_wen", 64'(wen_cnt - w0), 64'(NW));
        check("frame2_loaded", 64'(loaded_cnt - l0), 64'd1);
        check("frame2_drained", 64'(exp_q.size()), 64'd0);

        // reset after ten words, then a clean frame
        build_frame(2);
        expect_words(10, 1'b0);
        w0 = wen_cnt;
        send_frame(10 * B);
        idle_bits(1);
        check("partial_wen", 64'(wen_cnt - w0), 64'd10);
        check("partial_drained", 64'(exp_q.size()), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_wdata", 64'(lb.wdata), 64'd0);
        check("midrst_wrow", 64'(lb.wrow), 64'd0);
        check("midrst_wcol", 64'(lb.wcol), 64'd0);
        check("midrst_fidle", 64'(dut.r_f_state), 64'd0);
        rst = 1'b0;
        w0 = wen_cnt; l0 = loaded_cnt;
        idle_bits(3);
        check("postrst_no_wen", 64'(wen_cnt - w0), 64'd0);
        check("postrst_no_loaded", 64'(loaded_cnt - l0), 64'd0);
        build_frame(0);
        expect_words(NW, 1'b1);
        send_frame(FB);
        idle_bits(2);
        check("frame3_wen", 64'(wen_cnt - w0), 64'(NW));
        check("frame3_loaded", 64'(loaded_cnt - l0), 64'd1);
        check("frame3_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
